// File: rtl/instr_fill_responder_pkg.sv
// +--------------------------------------------------------------------------+
// | instr_fill_responder_pkg : shared types and beat helpers for line fills  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package instr_fill_responder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } fill_state_t;

  localparam int BEAT_BYTES = 8;
  localparam int BEAT_BITS  = BEAT_BYTES * 8;
  localparam int BEAT_SHIFT = 3;

  function automatic int beats_per_line(input int line_bytes);
    return line_bytes / BEAT_BYTES;
  endfunction

  function automatic int beat_cnt_width(input int line_bytes);
    return $clog2(line_bytes / BEAT_BYTES) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fill_responder_line_buffer.sv
// +--------------------------------------------------------------------------+
// | instr_fill_responder_line_buffer : NB x 64 line store, sync write,       |
// | combinational read. rev 1.0                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_fill_responder_line_buffer
  import instr_fill_responder_pkg::*;
#(
  parameter int NB    = 8,
  parameter int IDX_W = $clog2(NB)
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [IDX_W-1:0]     i_widx,
  input  logic [BEAT_BITS-1:0] i_wdata,
  input  logic [IDX_W-1:0]     i_ridx,
  output logic [BEAT_BITS-1:0] o_rdata
);

  // Contents are deliberately not reset: every entry is rewritten before it is read.
  logic [BEAT_BITS-1:0] r_mem [NB];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

`default_nettype wire

// File: rtl/instr_fill_responder.sv
// +--------------------------------------------------------------------------+
// | instr_fill_responder : fetches one cache line as 64-bit beats and        |
// | replays it to the cache set as a gapless burst. rev 1.0                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_fill_responder
  import instr_fill_responder_pkg::*;
#(
  parameter int B          = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  MissReq,
  input  logic [ADDR_WIDTH-1:0] MissAddr,
  output logic                  MemReq,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic [BEAT_BITS-1:0]  MemRdata,
  input  logic                  MemValid,
  output logic                  RepEnable,
  output logic [BEAT_BITS-1:0]  RepWord,
  output logic                  Busy
);

  localparam int NB    = beats_per_line(B);
  localparam int CNT_W = beat_cnt_width(B);
  localparam int IDX_W = CNT_W - 1;

  localparam logic [CNT_W-1:0]      NB_CNT    = CNT_W'(NB);
  localparam logic [CNT_W-1:0]      NB_LAST   = CNT_W'(NB - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(B - 1);

  fill_state_t             r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_line_base, w_line_base_nxt;
  logic [CNT_W-1:0]        r_req_cnt, w_req_cnt_nxt;
  logic [CNT_W-1:0]        r_rsp_cnt, w_rsp_cnt_nxt;
  logic [CNT_W-1:0]        r_str_cnt, w_str_cnt_nxt;
  logic                    r_outstanding, w_outstanding_nxt;
  logic                    r_mem_req, w_mem_req_nxt;
  logic [ADDR_WIDTH-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic                    r_rep_enable, w_rep_enable_nxt;
  logic [BEAT_BITS-1:0]    r_rep_word, w_rep_word_nxt;

  logic                    w_buf_we;
  logic [BEAT_BITS-1:0]    w_buf_rdata;
  logic [ADDR_WIDTH-1:0]   w_miss_base;
  logic [ADDR_WIDTH-1:0]   w_beat_addr;
  logic                    w_rsp_valid;

  assign w_miss_base = MissAddr & ~LINE_MASK;
  // Beat offset stays inside the aligned line, so the sum never carries past the line.
  assign w_beat_addr = r_line_base + (ADDR_WIDTH'(r_req_cnt) << BEAT_SHIFT);
  // Data returned in the request cycle itself would break the single-outstanding rule.
  assign w_rsp_valid = MemValid && r_outstanding && !r_mem_req;

  instr_fill_responder_line_buffer #(
    .NB    (NB),
    .IDX_W (IDX_W)
  ) u_line_buffer (
    .clk     (clk),
    .i_we    (w_buf_we),
    .i_widx  (r_rsp_cnt[IDX_W-1:0]),
    .i_wdata (MemRdata),
    .i_ridx  (r_str_cnt[IDX_W-1:0]),
    .o_rdata (w_buf_rdata)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_line_base_nxt   = r_line_base;
    w_req_cnt_nxt     = r_req_cnt;
    w_rsp_cnt_nxt     = r_rsp_cnt;
    w_str_cnt_nxt     = r_str_cnt;
    w_outstanding_nxt = r_outstanding;
    w_mem_req_nxt     = 1'b0;
    w_mem_addr_nxt    = r_mem_addr;
    w_rep_enable_nxt  = 1'b0;
    w_rep_word_nxt    = r_rep_word;
    w_buf_we          = 1'b0;

    case (r_state)
      IDLE: begin
        if (MissReq) begin
          w_line_base_nxt   = w_miss_base;
          w_mem_req_nxt     = 1'b1;
          w_mem_addr_nxt    = w_miss_base;
          w_outstanding_nxt = 1'b1;
          w_req_cnt_nxt     = CNT_ONE;
          w_rsp_cnt_nxt     = '0;
          w_str_cnt_nxt     = '0;
          w_state_nxt       = FETCH;
        end
      end

      FETCH: begin
        if (w_rsp_valid) begin
          w_buf_we          = 1'b1;
          w_rsp_cnt_nxt     = r_rsp_cnt + CNT_ONE;
          w_outstanding_nxt = 1'b0;
          if (r_rsp_cnt == NB_LAST) begin
            // Beat 0 goes out on the edge that stores the last beat, keeping the burst gapless.
            w_rep_enable_nxt = 1'b1;
            w_rep_word_nxt   = w_buf_rdata;
            w_str_cnt_nxt    = CNT_ONE;
            w_state_nxt      = STREAM;
          end else if (r_req_cnt < NB_CNT) begin
            w_mem_req_nxt     = 1'b1;
            w_mem_addr_nxt    = w_beat_addr;
            w_outstanding_nxt = 1'b1;
            w_req_cnt_nxt     = r_req_cnt + CNT_ONE;
          end
        end
      end

      STREAM: begin
        if (r_str_cnt < NB_CNT) begin
          w_rep_enable_nxt = 1'b1;
          w_rep_word_nxt   = w_buf_rdata;
          w_str_cnt_nxt    = r_str_cnt + CNT_ONE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end

      DRAIN: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_line_base   <= '0;
      r_req_cnt     <= '0;
      r_rsp_cnt     <= '0;
      r_str_cnt     <= '0;
      r_outstanding <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_rep_enable  <= 1'b0;
      r_rep_word    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_line_base   <= w_line_base_nxt;
      r_req_cnt     <= w_req_cnt_nxt;
      r_rsp_cnt     <= w_rsp_cnt_nxt;
      r_str_cnt     <= w_str_cnt_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_rep_enable  <= w_rep_enable_nxt;
      r_rep_word    <= w_rep_word_nxt;
    end
  end

  assign MemReq    = r_mem_req;
  assign MemAddr   = r_mem_addr;
  assign RepEnable = r_rep_enable;
  assign RepWord   = r_rep_word;
  assign Busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_instr_fill_responder.sv
// +--------------------------------------------------------------------------+
// | tb_instr_fill_responder : directed bench for the line-fill responder,    |
// | B=64 (8 beats). rev 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_instr_fill_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        MissReq = 1'b0;
  logic [31:0] MissAddr = 32'h0;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [63:0] MemRdata = 64'h0;
  logic        MemValid = 1'b0;
  logic        RepEnable;
  logic [63:0] RepWord;
  logic        Busy;

  int total = 0;
  int bad = 0;
  int req_viol = 0;
  bit rand_lat = 1'b0;
  bit data_mode = 1'b0;
  logic [31:0] addr_q[$];

  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  instr_fill_responder #(
    .B          (64),
    .ADDR_WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .MissReq   (MissReq),
    .MissAddr  (MissAddr),
    .MemReq    (MemReq),
    .MemAddr   (MemAddr),
    .MemRdata  (MemRdata),
    .MemValid  (MemValid),
    .RepEnable (RepEnable),
    .RepWord   (RepWord),
    .Busy      (Busy)
  );

  always #5 clk = ~clk;

  // mode 0: beat index within the line; mode 1: address-tagged pattern
  function automatic logic [63:0] mem_data(input logic [31:0] a, input bit mode);
    logic [63:0] d;
    if (mode) d = {a, ~a};
    else      d = {61'd0, a[5:3]};
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Backing-store model: one request outstanding, latency 1 or random 1..5 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 1'b0;
        MemValid = 1'b0;
      end else begin
        MemValid = 1'b0;
        if (MemReq && pend) req_viol++;
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            MemValid = 1'b1;
            MemRdata = mem_data(pend_addr, data_mode);
            pend = 1'b0;
          end
        end
        if (MemReq) begin
          if (MemValid) req_viol++;
          pend = 1'b1;
          pend_cnt = rand_lat ? int'($urandom_range(1, 5)) : 1;
          pend_addr = MemAddr;
          addr_q.push_back(MemAddr);
        end
      end
    end
  end

  task automatic start_miss(input logic [31:0] a);
    @(negedge clk);
    MissReq = 1'b1;
    MissAddr = a;
  endtask

  // Called on the negedge of the cycle in which MissReq is sampled high; returns on the DRAIN negedge.
  task automatic do_fill(input logic [31:0] base, input bit chk_lat, input bit noisy,
                         input bit hold, input logic [31:0] hold_addr);
    int k;
    k = 0;
    addr_q.delete();
    do begin
      @(negedge clk);
      k++;
      if (noisy) begin
        MissReq = 1'($urandom_range(0, 1));
        MissAddr = $urandom;
      end else begin
        MissReq = 1'b0;
      end
      if (k == 1) chk("busy_rise", 64'(Busy), 64'd1);
    end while (!RepEnable && k < 200);
    chk("first_beat_seen", 64'(RepEnable), 64'd1);
    if (chk_lat) chk("miss_to_beat_cycles", 64'(k), 64'd17);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (noisy) begin
          MissReq = 1'($urandom_range(0, 1));
          MissAddr = $urandom;
        end
      end
      chk("beat_enable", 64'(RepEnable), 64'd1);
      chk("beat_word", RepWord, mem_data(base + 32'(8 * i), data_mode));
    end
    @(negedge clk);
    if (hold) begin
      MissReq = 1'b1;
      MissAddr = hold_addr;
    end else if (noisy) begin
      MissReq = 1'b1;
      MissAddr = $urandom;
    end else begin
      MissReq = 1'b0;
    end
    chk("drain_enable", 64'(RepEnable), 64'd0);
    chk("drain_busy", 64'(Busy), 64'd1);
    chk("req_count", 64'(addr_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < addr_q.size(); i++) begin
      chk("mem_addr", 64'(addr_q[i]), 64'(base + 32'(8 * i)));
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    MissReq = 1'b0;
    chk("idle_busy", 64'(Busy), 64'd0);
    chk("idle_memreq", 64'(MemReq), 64'd0);
    @(negedge clk);
    chk("idle_stays", 64'(Busy), 64'd0);
  endtask

  initial begin
    int k;
    int anomaly;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_rep_enable", 64'(RepEnable), 64'd0);
    chk("rst_memreq", 64'(MemReq), 64'd0);
    chk("rst_memaddr", 64'(MemAddr), 64'd0);
    chk("rst_repword", RepWord, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic fill, 1-cycle memory, data = beat index
    data_mode = 1'b0;
    rand_lat = 1'b0;
    start_miss(32'h0000_1234);
    do_fill(32'h0000_1200, 1'b1, 1'b0, 1'b0, 32'h0);
    idle_check();
    chk("repword_holds", RepWord, 64'd7);

    // Variable memory latency
    data_mode = 1'b1;
    rand_lat = 1'b1;
    start_miss(32'h0002_0A7C);
    do_fill(32'h0002_0A40, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_check();
    chk("no_overlapping_req", 64'(req_viol), 64'd0);

    // MissReq noise while busy, then a held MissReq across DRAIN starts the next fill
    rand_lat = 1'b0;
    start_miss(32'h0000_4000);
    do_fill(32'h0000_4000, 1'b1, 1'b1, 1'b1, 32'h0000_8010);
    @(negedge clk);
    chk("idle_after_drain", 64'(Busy), 64'd0);
    do_fill(32'h0000_8000, 1'b1, 1'b0, 1'b0, 32'h0);
    idle_check();

    // Top-of-memory line
    start_miss(32'hFFFF_FFF8);
    do_fill(32'hFFFF_FFC0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle_check();

    // Asynchronous reset in the middle of the burst
    start_miss(32'h0000_3000);
    k = 0;
    do begin
      @(negedge clk);
      MissReq = 1'b0;
      k++;
    end while (!RepEnable && k < 200);
    chk("mid_first_beat_seen", 64'(RepEnable), 64'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rep_enable", 64'(RepEnable), 64'd0);
    chk("mid_rst_memreq", 64'(MemReq), 64'd0);
    chk("mid_rst_busy", 64'(Busy), 64'd0);
    chk("mid_rst_repword", RepWord, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    anomaly = 0;
    repeat (30) begin
      @(negedge clk);
      if (RepEnable || Busy || MemReq) anomaly++;
    end
    chk("post_reset_quiet", 64'(anomaly), 64'd0);
    chk("final_no_overlap", 64'(req_viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
